lgn_image_sender: RTL and testbench

Host-side transmitter for the classifier's byte-serial image load port. It accepts a 256-bit binarized 16×16 digit image, streams it as 32 bytes with an active-low write strobe, and waits a fixed settle time. It then captures the classifier's best-category index and popcount value. It sits in the test harness or FPGA wrapper that drives the logic-gate-network MNIST core.

---
 rtl/lgn_image_sender.sv | 175 +++++++++++++++++
 tb/tb_lgn_image_sender.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lgn_image_sender.sv
// lgn_image_sender
//   Host-side transmitter for the classifier's byte-serial image load port.
//   Accepts an 8*BYTES-bit binarized image and streams it MSB-first, one byte
//   per cycle, with an active-low write strobe. It then idles SETTLE_CYCLES
//   cycles and captures the classifier's best-category index and popcount.
//
//   Parameters: BYTES (bytes per image), SETTLE_CYCLES (1..255).
//   Ports:
//     clk, rst_n (async, active-low)
//     start, image           : transaction request and image (bit W-1 first)
//     data_out, we_n         : byte bus and active-low strobe to the classifier
//     result_index_in/_value_in : classifier result inputs
//     busy, done, result_valid, result_index, result_value : status / result
//   Optional feature macro LGN_SENDER_LABEL_CHECK_EN adds:
//     label (in), match (out), error_count (out, saturating at 255)
//   All outputs are registered.
module lgn_image_sender #(
   parameter int unsigned BYTES         = 32,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [8*BYTES-1:0] image,
   output logic [7:0]         data_out,
   output logic               we_n,
   input  logic [3:0]         result_index_in,
   input  logic [7:0]         result_value_in,
   output logic               busy,
   output logic               done,
   output logic               result_valid,
   output logic [3:0]         result_index,
   output logic [7:0]         result_value
`ifdef LGN_SENDER_LABEL_CHECK_EN
   ,
   input  logic [3:0]         label,
   output logic               match,
   output logic [7:0]         error_count
`endif
);

   localparam int unsigned W  = 8 * BYTES;
   localparam int unsigned CW = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [CW-1:0] LAST_BYTE   = CW'(BYTES - 1);
   localparam logic [7:0]    LAST_SETTLE = 8'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SETTLE} state_e;

   state_e         state_q, state_d;
   logic [W-1:0]   shreg_q, shreg_d;
   logic [CW-1:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]     settle_cnt_q, settle_cnt_d;
   logic [7:0]     data_out_q, data_out_d;
   logic           we_n_q, we_n_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           result_valid_q, result_valid_d;
   logic [3:0]     result_index_q, result_index_d;
   logic [7:0]     result_value_q, result_value_d;
`ifdef LGN_SENDER_LABEL_CHECK_EN
   logic [3:0]     label_q, label_d;
   logic           match_q, match_d;
   logic [7:0]     error_count_q, error_count_d;
`endif

   always_comb begin
      state_d        = state_q;
      shreg_d        = shreg_q;
      byte_cnt_d     = byte_cnt_q;
      settle_cnt_d   = settle_cnt_q;
      done_d         = 1'b0;
      result_valid_d = result_valid_q;
      result_index_d = result_index_q;
      result_value_d = result_value_q;
`ifdef LGN_SENDER_LABEL_CHECK_EN
      label_d        = label_q;
      match_d        = match_q;
      error_count_d  = error_count_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               shreg_d        = image;
               byte_cnt_d     = '0;
               result_valid_d = 1'b0;
               state_d        = LOAD;
`ifdef LGN_SENDER_LABEL_CHECK_EN
               label_d        = label;
`endif
            end
         end
         LOAD: begin
            shreg_d    = {shreg_q[W-9:0], 8'h00};
            byte_cnt_d = byte_cnt_q + CW'(1);
            if (byte_cnt_q == LAST_BYTE) begin
               state_d      = SETTLE;
               settle_cnt_d = '0;
            end
         end
         SETTLE: begin
            settle_cnt_d = settle_cnt_q + 8'd1;
            if (settle_cnt_q == LAST_SETTLE) begin
               result_index_d = result_index_in;
               result_value_d = result_value_in;
               result_valid_d = 1'b1;
               done_d         = 1'b1;
               state_d        = IDLE;
`ifdef LGN_SENDER_LABEL_CHECK_EN
               match_d = (result_index_in == label_q);
               if ((result_index_in != label_q) && (error_count_q != 8'hFF))
                  error_count_d = error_count_q + 8'd1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      // Bus outputs are derived from the next state so that they are
      // registered yet line up with the state they describe.
      data_out_d = (state_d == LOAD) ? shreg_d[W-1 -: 8] : 8'h00;
      we_n_d     = (state_d != LOAD);
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         shreg_q        <= '0;
         byte_cnt_q     <= '0;
         settle_cnt_q   <= '0;
         data_out_q     <= '0;
         we_n_q         <= 1'b1;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         result_valid_q <= 1'b0;
         result_index_q <= '0;
         result_value_q <= '0;
`ifdef LGN_SENDER_LABEL_CHECK_EN
         label_q        <= '0;
         match_q        <= 1'b0;
         error_count_q  <= '0;
`endif
      end else begin
         state_q        <= state_d;
         shreg_q        <= shreg_d;
         byte_cnt_q     <= byte_cnt_d;
         settle_cnt_q   <= settle_cnt_d;
         data_out_q     <= data_out_d;
         we_n_q         <= we_n_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         result_valid_q <= result_valid_d;
         result_index_q <= result_index_d;
         result_value_q <= result_value_d;
`ifdef LGN_SENDER_LABEL_CHECK_EN
         label_q        <= label_d;
         match_q        <= match_d;
         error_count_q  <= error_count_d;
`endif
      end
   end

   assign data_out     = data_out_q;
   assign we_n         = we_n_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign result_valid = result_valid_q;
   assign result_index = result_index_q;
   assign result_value = result_value_q;
`ifdef LGN_SENDER_LABEL_CHECK_EN
   assign match        = match_q;
   assign error_count  = error_count_q;
`endif

endmodule

// File: tb/tb_lgn_image_sender.sv
// Directed testbench for lgn_image_sender (default parameters).
module tb_lgn_image_sender;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [255:0] image;
   logic [7:0]   data_out;
   logic         we_n;
   logic [3:0]   result_index_in;
   logic [7:0]   result_value_in;
   logic         busy;
   logic         done;
   logic         result_valid;
   logic [3:0]   result_index;
   logic [7:0]   result_value;
`ifdef LGN_SENDER_LABEL_CHECK_EN
   logic [3:0]   label;
   logic         match;
   logic [7:0]   error_count;
`endif

   int total  = 0;
   int passed = 0;
   int failed = 0;

   logic [255:0] img1, img_a, img_b;

   always #5 clk = ~clk;

   lgn_image_sender #(.BYTES(32), .SETTLE_CYCLES(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .image           (image),
      .data_out        (data_out),
      .we_n            (we_n),
      .result_index_in (result_index_in),
      .result_value_in (result_value_in),
      .busy            (busy),
      .done            (done),
      .result_valid    (result_valid),
      .result_index    (result_index),
      .result_value    (result_value)
`ifdef LGN_SENDER_LABEL_CHECK_EN
      ,
      .label           (label),
      .match           (match),
      .error_count     (error_count)
`endif
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] byte_of(input logic [255:0] img, input int k);
      return img[255-8*k -: 8];
   endfunction

   // Called one step after the accept edge; checks all 32 bytes through a
   // receiver model. Optionally drives a competing start at byte inj_k.
   task automatic send_check(input string tag, input logic [255:0] img,
                             input int inj_k, input logic [255:0] inj_img);
      logic [255:0] x;
      x = '0;
      for (int k = 0; k < 32; k++) begin
         chk({tag, "_we_n"}, 256'(we_n), 256'(1'b0));
         chk({tag, "_byte"}, 256'(data_out), 256'(byte_of(img, k)));
         x = {x[247:0], data_out};
         if (k == inj_k) begin
            start = 1'b1;
            image = inj_img;
         end else if (k == inj_k + 1) begin
            start = 1'b0;
         end
         step();
      end
      chk({tag, "_rx_image"}, x, img);
      chk({tag, "_settle_we_n"}, 256'(we_n), 256'(1'b1));
      chk({tag, "_settle_busy"}, 256'(busy), 256'(1'b1));
   endtask

   // Called one step after E32; expects done exactly at E36.
   task automatic finish_check(input string tag, input logic [3:0] idx, input logic [7:0] val);
      int early;
      early = 0;
      repeat (3) begin
         step();
         if (done) early++;
      end
      chk({tag, "_no_early_done"}, 256'(early), 256'(0));
      step();
      chk({tag, "_done"}, 256'(done), 256'(1'b1));
      chk({tag, "_busy_low"}, 256'(busy), 256'(1'b0));
      chk({tag, "_rvalid"}, 256'(result_valid), 256'(1'b1));
      chk({tag, "_index"}, 256'(result_index), 256'(idx));
      chk({tag, "_value"}, 256'(result_value), 256'(val));
   endtask

   initial begin
      int seen;
      rst_n = 1'b0;
      start = 1'b0;
      image = '0;
      result_index_in = '0;
      result_value_in = '0;
`ifdef LGN_SENDER_LABEL_CHECK_EN
      label = '0;
`endif
      img1 = '0;
      img1[255:248] = 8'h80;
      img1[7:0]     = 8'h01;
      for (int k = 0; k < 32; k++) img_a[255-8*k -: 8] = 8'(k * 7 + 3);
      img_b = ~img_a;

      // Reset state
      step();
      step();
      chk("rst_data_out", 256'(data_out), 256'(8'h00));
      chk("rst_we_n", 256'(we_n), 256'(1'b1));
      chk("rst_busy", 256'(busy), 256'(1'b0));
      chk("rst_done", 256'(done), 256'(1'b0));
      chk("rst_rvalid", 256'(result_valid), 256'(1'b0));
      chk("rst_index", 256'(result_index), 256'(4'd0));
      chk("rst_value", 256'(result_value), 256'(8'd0));
      rst_n = 1'b1;
      step();

      // Basic send and result capture
      result_index_in = 4'd7;
      result_value_in = 8'd183;
      image = img1;
      start = 1'b1;
      step();
      start = 1'b0;
      image = img_b;
      send_check("basic", img1, -10, '0);
      finish_check("basic", 4'd7, 8'd183);
      step();
      chk("basic_done_pulse", 256'(done), 256'(1'b0));
      chk("basic_rvalid_hold", 256'(result_valid), 256'(1'b1));

      // Start while busy is ignored
      result_index_in = 4'd2;
      result_value_in = 8'd9;
      image = img_a;
      start = 1'b1;
      step();
      start = 1'b0;
      send_check("busy_start", img_a, 10, img_b);
      finish_check("busy_start", 4'd2, 8'd9);
      seen = 0;
      repeat (40) begin
         step();
         if (done) seen++;
      end
      chk("busy_start_single_done", 256'(seen), 256'(0));

      // Back-to-back with start held
      result_index_in = 4'd15;
      result_value_in = 8'd0;
      image = img_a;
      start = 1'b1;
      step();
      chk("b2b_rvalid_drop1", 256'(result_valid), 256'(1'b0));
      send_check("b2b_first", img_a, -10, '0);
      finish_check("b2b_first", 4'd15, 8'd0);
      image = img1;
      step();
      chk("b2b_accept_busy", 256'(busy), 256'(1'b1));
      chk("b2b_accept_rvalid", 256'(result_valid), 256'(1'b0));
      chk("b2b_accept_done", 256'(done), 256'(1'b0));
      chk("b2b_byte0_we_n", 256'(we_n), 256'(1'b0));
      chk("b2b_byte0", 256'(data_out), 256'(8'h80));
      start = 1'b0;

      // Reset mid-LOAD at byte 20
      repeat (20) step();
      chk("midload_we_n", 256'(we_n), 256'(1'b0));
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_we_n", 256'(we_n), 256'(1'b1));
      chk("abort_busy", 256'(busy), 256'(1'b0));
      chk("abort_done", 256'(done), 256'(1'b0));
      step();
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         step();
         if (done || result_valid) seen++;
      end
      chk("abort_no_result", 256'(seen), 256'(0));
      result_index_in = 4'd3;
      result_value_in = 8'd200;
      image = img_a;
      start = 1'b1;
      step();
      start = 1'b0;
      send_check("after_abort", img_a, -10, '0);
      finish_check("after_abort", 4'd3, 8'd200);

`ifdef LGN_SENDER_LABEL_CHECK_EN
      // Label check
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk("lbl_rst_err", 256'(error_count), 256'(8'd0));
      chk("lbl_rst_match", 256'(match), 256'(1'b0));
      label = 4'd3;
      result_index_in = 4'd5;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (36) step();
      chk("lbl_mismatch_done", 256'(done), 256'(1'b1));
      chk("lbl_mismatch_match", 256'(match), 256'(1'b0));
      chk("lbl_mismatch_err", 256'(error_count), 256'(8'd1));
      label = 4'd5;
      start = 1'b1;
      step();
      start = 1'b0;
      label = 4'd0;
      repeat (36) step();
      chk("lbl_match_match", 256'(match), 256'(1'b1));
      chk("lbl_match_err", 256'(error_count), 256'(8'd1));
      label = 4'd3;
      repeat (300) begin
         start = 1'b1;
         step();
         start = 1'b0;
         repeat (36) step();
      end
      chk("lbl_sat_err", 256'(error_count), 256'(8'd255));
      chk("lbl_sat_match", 256'(match), 256'(1'b0));
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
